uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Sequencing FSM for the UART receiver datapath.
- Detects the start bit on the serial line, counts oversample ticks to the mid-point of each bit, and issues one-cycle strobes to the shift register, the parity checker and the stop checker.
- Collects their error flags and reports frame completion.
- Sits between the baud generator (tick source) and the receiver datapath modules.

Parameters:
- OVERSAMPLE, 16, sample ticks per bit period (even, ≥4).
- DATA_BITS, 8, data bits per frame (5–9).
- PARITY_EN, 1, 1 = one parity bit between data and stop; 0 = none.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-clk pulse at OVERSAMPLE × baud rate.
- rx_in  in  1  asynchronous serial line, idle high.
- parity_error  in  1  from parity checker, valid in the cycle check_parity is high.
- stop_error  in  1  from stop checker, valid in the cycle check_stop is high.
- shift_en  out  1  one-clk strobe: datapath samples rx and shifts one data bit, LSB first.
- check_parity  out  1  one-clk strobe at parity-bit mid-point.
- check_stop  out  1  one-clk strobe at stop-bit mid-point.
- rx_done  out  1  one-clk pulse: frame finished.
- frame_error  out  1  valid with rx_done: stop or parity error in this frame.
- busy  out  1  high from start detect until rx_done.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Reset mid-frame aborts the frame with no rx_done.
- rx_in passes through a 2-flop synchronizer, giving rx_s with 2 clk latency. All decisions use rx_s.
- Sample counter (tick_cnt) advances only on sample_tick; it is cleared on every state change.
- Bit counter (bit_cnt) counts data bits, 0..DATA_BITS-1.
- IDLE: on sample_tick with rx_s=0 -> START; busy=1 next cycle.
- START: on tick with tick_cnt = OVERSAMPLE/2-1 (mid start bit):
  - rx_s=1 -> IDLE (glitch rejected, busy drops, no strobes).
  - rx_s=0 -> DATA.
- DATA: on tick with tick_cnt = OVERSAMPLE-1:
  - shift_en=1 for exactly that clk; bit_cnt++.
  - After strobe number DATA_BITS -> PARITY if PARITY_EN, else STOP.
- PARITY: on tick with tick_cnt = OVERSAMPLE-1: check_parity=1 for one clk; parity_error registered into par_err in that cycle -> STOP.
- STOP: on tick with tick_cnt = OVERSAMPLE-1: check_stop=1 for one clk; stop_error registered into stp_err -> DONE.
- DONE (1 clk):
  - rx_done=1, frame_error = par_err | stp_err; busy=0.
  - If stp_err and rx_s=0 -> BREAK; else -> IDLE.
- BREAK: wait until rx_s=1 (no tick required) -> IDLE. A line held low never retriggers a frame.
- Strobes are mutually exclusive; at most one is high per clk. None are asserted outside their state.
- The controller exits at the stop-bit mid-point, so a start bit beginning half a bit later is still detected. Back-to-back frames are received without loss.
- sample_tick is ignored in DONE.
- par_err and stp_err clear on entry to START.
- Tick and rx edge in the same clk: the edge is evaluated as seen through the synchronizer, with no special case.
- Counter widths: $clog2(OVERSAMPLE) bits for tick_cnt, $clog2(DATA_BITS+1) bits for bit_cnt. No wrap occurs, because each counter is cleared on state change.

Decomposition:
- Shared package uart_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP, DONE, BREAK.
  - Default OVERSAMPLE and DATA_BITS constants, shared with the baud generator and transmitter.
- One sub-module, uart_sync_2ff: 2-flop synchronizer for rx_in, reusable by other UART inputs.

Test Plan (OVERSAMPLE=16, DATA_BITS=8, PARITY_EN=1, tick every 4 clk unless stated):
- Frame 0xA5, even parity correct, stop=1 -> 8 shift_en strobes spaced 64 clk apart, 1 check_parity, 1 check_stop, rx_done=1 with frame_error=0, busy low afterwards.
- Start pulse low for 5 ticks only -> no strobes, no rx_done, busy returns 0 within 1 clk of the mid-start check.
- Frame 0x3C with stop bit forced 0, line returns high 2 bits later -> rx_done with frame_error=1; FSM stays in BREAK until rx high; no new frame while the line is low.
- parity_error=1 driven during check_parity -> rx_done with frame_error=1, stop_error=0.
- Two back-to-back frames 0x00 then 0xFF, no idle gap -> two rx_done pulses, 16 shift_en total, second frame's start detected.
- rst asserted during DATA bit 4 -> all outputs 0 next clk, no rx_done; next clean frame 0x5A is received normally.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receive-controller state encoding and the default frame
// geometry. The baud generator and the transmitter use the same defaults.
package uart_pkg;

    // Default sample ticks per bit period and data bits per frame.
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its neighbours.
// master : the controller. It takes the tick, the serial line and the checker
//          error flags, and drives the strobes and the frame status.
// slave  : the surrounding datapath, meaning the baud generator, the line,
//          the shift register and the parity/stop checkers.
interface uart_rx_ctrl_if;
    logic sample_tick;   // one-clk pulse at OVERSAMPLE x baud
    logic rx_in;         // raw serial line, idle high
    logic parity_error;  // valid while check_parity is high
    logic stop_error;    // valid while check_stop is high
    logic shift_en;      // sample and shift one data bit, LSB first
    logic check_parity;  // parity-bit mid-point strobe
    logic check_stop;    // stop-bit mid-point strobe
    logic rx_done;       // frame finished
    logic frame_error;   // valid with rx_done
    logic busy;          // start detect .. rx_done

    modport master (
        input  sample_tick, rx_in, parity_error, stop_error,
        output shift_en, check_parity, check_stop, rx_done, frame_error, busy
    );

    modport slave (
        output sample_tick, rx_in, parity_error, stop_error,
        input  shift_en, check_parity, check_stop, rx_done, frame_error, busy
    );
endinterface

// File: rtl/uart_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input. Latency is 2 clk.
// Ports:
//   clk, rst  system clock and synchronous active-high reset
//   d         asynchronous input
//   q         synchronized output
// RESET_VAL sets the reset level of both flops. A serial line uses 1 here,
// so that leaving reset never looks like a start edge.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing FSM.
// The controller finds the start bit, counts oversample ticks to the middle of
// each bit, and issues one-clk strobes to the shift register and to the
// parity and stop checkers. It collects the checker error flags and reports
// frame completion.
// Ports:
//   clk, rst  system clock and synchronous active-high reset
//   bus       uart_rx_ctrl_if.master, which carries the tick, the line, the
//             checker errors, the strobes, rx_done, frame_error and busy
// Every output is registered.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int PARITY_EN  = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_ctrl_if.master bus
);
    localparam int TC_W = $clog2(OVERSAMPLE);
    localparam int BC_W = $clog2(DATA_BITS + 1);
    localparam logic [TC_W-1:0] TICK_MID  = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0] TICK_LAST = TC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(DATA_BITS - 1);

    rx_state_e       state;
    logic [TC_W-1:0] tick_cnt;
    logic [BC_W-1:0] bit_cnt;
    logic            par_err;
    logic            stp_err;
    logic            rx_s;

    uart_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx_in),
        .q   (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            tick_cnt         <= '0;
            bit_cnt          <= '0;
            par_err          <= 1'b0;
            stp_err          <= 1'b0;
            bus.shift_en     <= 1'b0;
            bus.check_parity <= 1'b0;
            bus.check_stop   <= 1'b0;
            bus.rx_done      <= 1'b0;
            bus.frame_error  <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            // All strobes default low, so each one is a single-clk pulse.
            bus.shift_en     <= 1'b0;
            bus.check_parity <= 1'b0;
            bus.check_stop   <= 1'b0;
            bus.rx_done      <= 1'b0;
            bus.frame_error  <= 1'b0;

            // The parity checker answers in the cycle the strobe is visible.
            // That cycle is already the first cycle of STOP.
            if (bus.check_parity)
                par_err <= bus.parity_error;

            case (state)
                IDLE: begin
                    if (bus.sample_tick && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        par_err  <= 1'b0;
                        stp_err  <= 1'b0;
                        bus.busy <= 1'b1;
                    end
                end

                START: begin
                    if (bus.sample_tick) begin
                        if (tick_cnt == TICK_MID) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                // Line went high again before mid-bit, so this was a glitch.
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (bus.sample_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt     <= '0;
                            bus.shift_en <= 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (bus.sample_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt         <= '0;
                            bus.check_parity <= 1'b1;
                            state            <= STOP;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    // Stay one extra cycle after the strobe so that the stop
                    // checker's answer is held in stp_err before DONE uses it.
                    if (bus.check_stop) begin
                        stp_err  <= bus.stop_error;
                        tick_cnt <= '0;
                        state    <= DONE;
                    end else if (bus.sample_tick) begin
                        if (tick_cnt == TICK_LAST)
                            bus.check_stop <= 1'b1;
                        else
                            tick_cnt <= tick_cnt + 1'b1;
                    end
                end

                DONE: begin
                    // Ticks are deliberately ignored here.
                    bus.rx_done     <= 1'b1;
                    bus.frame_error <= par_err | stp_err;
                    bus.busy        <= 1'b0;
                    tick_cnt        <= '0;
                    // A bad stop bit on a line that is still low is treated as
                    // a break. Wait for the line to idle so it cannot retrigger.
                    state <= (stp_err && !rx_s) ? BREAK : IDLE;
                end

                BREAK: begin
                    if (rx_s)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;
    localparam int OS      = 16;
    localparam int DB      = 8;
    localparam int TICK_DV = 4;
    localparam int BIT_CLK = OS * TICK_DV;

    typedef struct {
        int   kind;    // 0 shift, 1 parity check, 2 stop check, 3 done
        logic val;     // line level at the strobe, or frame_error for done
        logic first;   // first strobe of a frame: no spacing check
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    logic par_inj = 1'b0;
    logic [1:0] div = '0;
    longint cyc = 0;
    int total = 0;
    int bad = 0;
    ev_t exp_q[$];
    longint last_strobe = 0;

    uart_rx_ctrl_if bus();

    uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        div <= div + 2'd1;
        bus.sample_tick <= (div == 2'd3);
        cyc <= cyc + 1;
    end

    // Line and checker models: the stop checker flags a low line at the
    // stop strobe, and the parity checker raises an error when told to.
    assign bus.rx_in        = rx_line;
    assign bus.parity_error = bus.check_parity & par_inj;
    assign bus.stop_error   = bus.check_stop & ~rx_line;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: whenever the DUT presents a strobe or done, compare it with the oldest pending expectation.
    always @(negedge clk) begin
        int n;
        int kind;
        ev_t e;
        if (!rst) begin
            n = int'(bus.shift_en) + int'(bus.check_parity) + int'(bus.check_stop) + int'(bus.rx_done);
            if (n != 0) begin
                kind = bus.shift_en ? 0 : bus.check_parity ? 1 : bus.check_stop ? 2 : 3;
                chk("one_hot", n, 1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got kind %0d expected none", kind);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    if (kind == e.kind) begin
                        if (kind == 3) begin
                            chk("frame_error", int'(bus.frame_error), int'(e.val));
                            chk("busy_at_done", int'(bus.busy), 0);
                        end else begin
                            chk("strobe_line", int'(rx_line), int'(e.val));
                            chk("busy_in_frame", int'(bus.busy), 1);
                            if (!e.first)
                                chk("strobe_spacing", int'(cyc - last_strobe), BIT_CLK);
                            last_strobe = cyc;
                        end
                    end
                end
            end
        end
    end

    task automatic tick_wait();
        @(negedge clk);
        while (!bus.sample_tick) @(negedge clk);
    endtask

    task automatic hold(input logic v, input int n);
        rx_line = v;
        repeat (n) tick_wait();
    endtask

    // Reference model: a well-formed frame yields DB shifts that carry the
    // data LSB first, one parity and one stop check, and then done. The frame
    // has an error if parity was flagged or the stop bit was low.
    task automatic send_frame(input logic [7:0] d, input logic pinj, input logic stop_bit);
        ev_t e;
        logic p;
        p = ^d;
        for (int i = 0; i < DB; i++) begin
            e.kind = 0; e.val = d[i]; e.first = (i == 0);
            exp_q.push_back(e);
        end
        e.kind = 1; e.val = p;        e.first = 1'b0; exp_q.push_back(e);
        e.kind = 2; e.val = stop_bit; e.first = 1'b0; exp_q.push_back(e);
        e.kind = 3; e.val = pinj | ~stop_bit; e.first = 1'b0; exp_q.push_back(e);
        par_inj = pinj;
        hold(1'b0, OS);
        for (int i = 0; i < DB; i++) hold(d[i], OS);
        hold(p, OS);
        hold(stop_bit, OS);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4 * BIT_CLK) begin
            @(negedge clk);
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_shift_en"}, int'(bus.shift_en), 0);
        chk({nm, "_check_parity"}, int'(bus.check_parity), 0);
        chk({nm, "_check_stop"}, int'(bus.check_stop), 0);
        chk({nm, "_rx_done"}, int'(bus.rx_done), 0);
        chk({nm, "_frame_error"}, int'(bus.frame_error), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
    endtask

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] d;
        ev_t e;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        hold(1'b1, 2 * OS);

        // Clean frame 0xA5.
        send_frame(8'hA5, 1'b0, 1'b1);
        hold(1'b1, OS);
        drain("drain_a5");
        chk("busy_after_a5", int'(bus.busy), 0);

        // Start glitch 5 ticks long: frame rejected at mid start bit.
        hold(1'b0, 5);
        chk("busy_glitch_start", int'(bus.busy), 1);
        hold(1'b1, 5);
        chk("busy_glitch_reject", int'(bus.busy), 0);
        hold(1'b1, 2 * OS);
        chk("glitch_no_events", exp_q.size(), 0);

        // Bad stop bit, then the line stays low for two more bit times.
        send_frame(8'h3C, 1'b0, 1'b0);
        hold(1'b0, OS / 2);
        chk("busy_break_1", int'(bus.busy), 0);
        hold(1'b0, OS + OS / 2);
        chk("busy_break_2", int'(bus.busy), 0);
        hold(1'b1, 2 * OS);
        drain("drain_break");

        // Parity error injected.
        send_frame(8'h6E, 1'b1, 1'b1);
        hold(1'b1, OS);
        drain("drain_parity");

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        hold(1'b1, OS);
        drain("drain_b2b");

        // Reset while the FSM is in data bit 4: only four shifts occur.
        d = 8'h96;
        par_inj = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.kind = 0; e.val = d[i]; e.first = (i == 0);
            exp_q.push_back(e);
        end
        hold(1'b0, OS);
        for (int i = 0; i < 4; i++) hold(d[i], OS);
        hold(d[4], 4);
        chk("pre_reset_shifts", exp_q.size(), 0);
        rst = 1'b1;
        rx_line = 1'b1;
        @(negedge clk);
        chk_all_zero("midframe_reset");
        rst = 1'b0;
        hold(1'b1, 2 * OS);
        chk("no_done_after_reset", exp_q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        hold(1'b1, OS);
        drain("drain_5a");

        // Random frames with random parity errors and idle gaps.
        for (int k = 0; k < 12; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) == 0), 1'b1);
            hold(1'b1, $urandom_range(0, 20));
        end
        hold(1'b1, OS);
        drain("drain_random");
        chk("busy_final", int'(bus.busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
